// File: rtl/mem_write_checker.sv
// Memory write-bus monitor: compares processor writes against a loadable expected table
// and reports pass/fail/timeout. Define MEM_CHK_IGNORE_EN to discard non-matching writes in an address window.
module mem_write_checker #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int NUM_EXP        = 4,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter logic [ADDR_W-1:0] IGNORE_BASE = ADDR_W'(96),
    parameter logic [ADDR_W-1:0] IGNORE_MASK = '0,
    localparam int IDX_W = ($clog2(NUM_EXP + 1) > 1) ? $clog2(NUM_EXP + 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] adr,
    input  logic [DATA_W-1:0] write_data,
    input  logic              exp_we,
    input  logic [IDX_W-1:0]  exp_idx,
    input  logic [ADDR_W-1:0] exp_adr,
    input  logic [DATA_W-1:0] exp_data,
    input  logic [IDX_W-1:0]  exp_num,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic              timeout,
    output logic [IDX_W-1:0]  match_count,
    output logic [ADDR_W-1:0] fail_adr,
    output logic [DATA_W-1:0] fail_data
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0] NUM_MAX  = IDX_W'(NUM_EXP);

`ifdef MEM_CHK_IGNORE_EN
    localparam bit IGN_EN = 1'b1;
`else
    localparam bit IGN_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ARMED, S_PASS, S_FAIL, S_TIMEOUT} state_t;

    state_t             state_q;
    logic [IDX_W-1:0]   match_q;
    logic [IDX_W-1:0]   num_q;
    logic [TMR_W-1:0]   timer_q;
    logic [ADDR_W-1:0]  fail_adr_q;
    logic [DATA_W-1:0]  fail_data_q;

    logic [ADDR_W-1:0]  tab_adr_q  [NUM_EXP];
    logic [DATA_W-1:0]  tab_data_q [NUM_EXP];

    logic [ADDR_W-1:0]  cur_adr;
    logic [DATA_W-1:0]  cur_data;
    logic [IDX_W-1:0]   match_d;
    logic [IDX_W-1:0]   num_d;
    logic               hit, ign, tmr_last, tab_we;

    // Current expected entry is selected by match count; out-of-range counts never occur while armed.
    always_comb begin
        cur_adr  = '0;
        cur_data = '0;
        for (int i = 0; i < NUM_EXP; i++) begin
            if (match_q == IDX_W'(i)) begin
                cur_adr  = tab_adr_q[i];
                cur_data = tab_data_q[i];
            end
        end
    end

    assign hit      = (adr == cur_adr) && (write_data == cur_data);
    assign ign      = IGN_EN && ((adr & ~IGNORE_MASK) == (IGNORE_BASE & ~IGNORE_MASK));
    assign tmr_last = (timer_q == TMR_LAST);
    assign match_d  = match_q + IDX_W'(1);
    assign num_d    = (exp_num > NUM_MAX) ? NUM_MAX : exp_num;
    assign tab_we   = exp_we && (exp_idx < NUM_MAX) && (state_q != S_ARMED);

    always_ff @(posedge clk) begin
        if (tab_we) begin
            for (int i = 0; i < NUM_EXP; i++) begin
                if (exp_idx == IDX_W'(i)) begin
                    tab_adr_q[i]  <= exp_adr;
                    tab_data_q[i] <= exp_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            match_q     <= '0;
            num_q       <= '0;
            timer_q     <= '0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
        end else if (state_q == S_ARMED) begin
            timer_q <= timer_q + TMR_W'(1);
            // Timeout is the default; a deciding write on the same edge overrides it.
            if (tmr_last)
                state_q <= S_TIMEOUT;
            if (mem_write) begin
                if (hit) begin
                    match_q <= match_d;
                    if (match_d == num_q)
                        state_q <= S_PASS;
                end else if (!ign) begin
                    state_q     <= S_FAIL;
                    fail_adr_q  <= adr;
                    fail_data_q <= write_data;
                end
            end
        end else if (start) begin
            num_q       <= num_d;
            match_q     <= '0;
            timer_q     <= '0;
            fail_adr_q  <= '0;
            fail_data_q <= '0;
            state_q     <= (num_d == '0) ? S_PASS : S_ARMED;
        end
    end

    assign pass        = (state_q == S_PASS);
    assign fail        = (state_q == S_FAIL);
    assign timeout     = (state_q == S_TIMEOUT);
    assign done        = pass | fail | timeout;
    assign match_count = match_q;
    assign fail_adr    = fail_adr_q;
    assign fail_data   = fail_data_q;

endmodule
